byte_decode_stream: RTL and testbench

- Sequential inverse of the combinational coefficient encoder (ByteDecode_d, FIPS 203): unpacks a packed little-endian byte stream into 256 D-bit coefficients.
- Bytes enter one per handshake. Coefficients leave one per handshake, zero-extended to 16 bits.
- For D=12, coefficients are reduced mod q=3329.
- Used on the decryption/decapsulation path to recover ciphertext and secret-key polynomials from serialized bytes.

---
 rtl/byte_decode_stream.sv | 138 +++++++++++++
 tb/tb_byte_decode_stream.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_decode_stream.sv
// Streaming ByteDecode_d: unpacks LSB-first packed bytes into 256 D-bit
// coefficients, one coefficient per output handshake, reduced mod Q when D==12.
module byte_decode_stream #(
  parameter int D        = 12,
  parameter int BYTE_LEN = 32,
  parameter int Q        = 3329
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] out_coef,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  localparam int BUF_W       = D + 7;
  localparam int TOTAL_BYTES = BYTE_LEN * D;
  localparam int NUM_COEF    = BYTE_LEN * 8;
  localparam int BCW         = $clog2(BUF_W + 1);
  localparam int BYW         = $clog2(TOTAL_BYTES + 1);
  localparam int CCW         = $clog2(NUM_COEF + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

  state_t           r_state;
  logic [BUF_W-1:0] r_buf;
  logic [BCW-1:0]   r_bit_cnt;
  logic [BYW-1:0]   r_byte_cnt;
  logic [CCW-1:0]   r_coef_cnt;
  logic [15:0]      r_out_coef;
  logic             r_out_valid;
  logic             r_busy;
  logic             r_done;

  logic             w_in_ready;
  logic             w_byte_hs;
  logic             w_extract;
  logic             w_out_hs;
  logic             w_last_coef;
  logic [BUF_W-1:0] w_byte_ext;
  logic [15:0]      w_raw16;
  logic [15:0]      w_coef;

  // Accepting a byte only while fewer than D bits are held keeps the buffer
  // from overflowing and makes accept/extract mutually exclusive.
  assign w_in_ready  = (r_state == S_RUN) && (r_bit_cnt < BCW'(D)) &&
                       (r_byte_cnt < BYW'(TOTAL_BYTES));
  assign w_byte_hs   = in_valid && w_in_ready;
  assign w_extract   = (r_state == S_RUN) && (r_bit_cnt >= BCW'(D)) &&
                       (!r_out_valid || out_ready);
  assign w_out_hs    = r_out_valid && out_ready;
  assign w_last_coef = (r_coef_cnt == CCW'(NUM_COEF - 1));
  assign w_byte_ext  = BUF_W'(in_byte) << r_bit_cnt;
  assign w_raw16     = 16'(r_buf[D-1:0]);

  // raw < 4096 < 2Q, so a single conditional subtraction fully reduces it.
  generate
    if (D == 12) begin : g_reduce
      assign w_coef = (w_raw16 >= 16'(Q)) ? (w_raw16 - 16'(Q)) : w_raw16;
    end else begin : g_pass
      assign w_coef = w_raw16;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_buf       <= '0;
      r_bit_cnt   <= '0;
      r_byte_cnt  <= '0;
      r_coef_cnt  <= '0;
      r_out_coef  <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state     <= S_RUN;
            r_busy      <= 1'b1;
            r_buf       <= '0;
            r_bit_cnt   <= '0;
            r_byte_cnt  <= '0;
            r_coef_cnt  <= '0;
            r_out_valid <= 1'b0;
          end
        end
        S_RUN: begin
          if (w_byte_hs) begin
            r_buf      <= r_buf | w_byte_ext;
            r_bit_cnt  <= r_bit_cnt + BCW'(8);
            r_byte_cnt <= r_byte_cnt + BYW'(1);
          end else if (w_extract) begin
            r_buf      <= r_buf >> D;
            r_bit_cnt  <= r_bit_cnt - BCW'(D);
            r_out_coef <= w_coef;
          end
          if (w_extract) begin
            r_out_valid <= 1'b1;
          end else if (w_out_hs) begin
            r_out_valid <= 1'b0;
          end
          if (w_out_hs) begin
            r_coef_cnt <= r_coef_cnt + CCW'(1);
            if (w_last_coef) begin
              r_state <= S_FINISH;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
        end
        S_FINISH: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_coef  = r_out_coef;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule

// File: tb/tb_byte_decode_stream.sv
// Scoreboard bench for byte_decode_stream: a bit-list ByteDecode model fills
// an expectation queue as bytes are accepted; outputs are popped and compared.
`timescale 1ns/1ps
module tb_byte_decode_stream;

  localparam int D  = 12;
  localparam int NB = 384;
  localparam int NC = 256;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, in_valid, in_ready, out_valid, out_ready, busy, done;
  logic [7:0]  in_byte;
  logic [15:0] out_coef;

  logic        d1_rst, d1_start, d1_in_valid, d1_in_ready, d1_out_valid;
  logic        d1_out_ready, d1_busy, d1_done;
  logic [7:0]  d1_in_byte;
  logic [15:0] d1_out_coef;

  byte_decode_stream #(.D(12), .BYTE_LEN(32), .Q(3329)) u_dut (
    .clk(clk), .rst(rst), .start(start), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready), .out_coef(out_coef), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done)
  );

  byte_decode_stream #(.D(1), .BYTE_LEN(32), .Q(3329)) u_dut_d1 (
    .clk(clk), .rst(d1_rst), .start(d1_start), .in_byte(d1_in_byte),
    .in_valid(d1_in_valid), .in_ready(d1_in_ready), .out_coef(d1_out_coef),
    .out_valid(d1_out_valid), .out_ready(d1_out_ready), .busy(d1_busy),
    .done(d1_done)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] stim [0:NB-1];
  int   mdl_bits[$];
  int   exp_q[$];
  int   got_q[$];
  int   hs_cnt = 0, done_cnt = 0, bytes_acc = 0;
  bit   expect_done = 0;
  bit   bp_req = 0, bp_hold = 0, rdy_full = 1;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    int c;
    for (int k = 0; k < 8; k++) mdl_bits.push_back(int'(b[k]));
    while (mdl_bits.size() >= D) begin
      c = 0;
      for (int j = 0; j < D; j++) c = c | (mdl_bits.pop_front() << j);
      if (c >= 3329) c = c - 3329;
      exp_q.push_back(c);
    end
  endtask

  // Monitor: all sampling on the falling edge, between active edges.
  initial begin : monitor
    int e;
    forever begin
      @(negedge clk);
      if (rst) begin
        mdl_bits.delete();
        exp_q.delete();
        hs_cnt = 0;
        bytes_acc = 0;
        expect_done = 0;
      end else begin
        if (start && !busy) begin
          hs_cnt = 0;
          bytes_acc = 0;
        end
        if (done) done_cnt++;
        if (expect_done) begin
          check_eq("done_timing", int'(done), 1);
          expect_done = 0;
        end
        if (in_valid && in_ready) begin
          model_byte(in_byte);
          bytes_acc++;
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            check_eq("sb_underflow", exp_q.size(), 1);
          end else begin
            e = exp_q.pop_front();
            $display("coef %0d: got %0d exp %0d", hs_cnt, out_coef, e);
            check_eq("coef", int'(out_coef), e);
            got_q.push_back(int'(out_coef));
          end
          hs_cnt++;
          if (hs_cnt == NC) expect_done = 1;
        end
      end
    end
  end

  initial begin : ready_drv
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (bp_hold)       out_ready = 1'b0;
      else if (rdy_full) out_ready = 1'b1;
      else               out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin : bp_proc
    int held;
    int waitc;
    forever begin
      @(posedge clk);
      if (bp_req) begin
        bp_req  = 0;
        bp_hold = 1;
        waitc   = 0;
        @(negedge clk);
        while (!out_valid && waitc < 200) begin
          @(negedge clk);
          waitc++;
        end
        check_eq("bp_start_valid", int'(out_valid), 1);
        held = int'(out_coef);
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          check_eq("bp_coef_hold", int'(out_coef), held);
          check_eq("bp_valid_hold", int'(out_valid), 1);
        end
        check_eq("bp_in_ready", int'(in_ready), 0);
        $display("backpressure held coef %0d for 10 cycles", held);
        bp_hold = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic send_bytes(input int n, input int gap_pct);
    int idx;
    int guard;
    bit hs;
    idx = 0;
    guard = 0;
    while (idx < n && guard < 20000) begin
      in_byte  = stim[idx];
      in_valid = ($urandom_range(0, 99) >= gap_pct);
      @(negedge clk);
      hs = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (hs) idx++;
      guard++;
    end
    in_valid = 1'b0;
    check_eq("send_count", idx, n);
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || out_valid) && g < 3000) begin
      tick(1);
      g++;
    end
    check_eq("drain_empty", exp_q.size(), 0);
  endtask

  task automatic rand_stim();
    for (int i = 0; i < NB; i++) stim[i] = 8'($urandom_range(0, 255));
  endtask

  initial begin : main
    int dc;
    int d1_got[$];
    int d1_exp[8];
    int g;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_byte = 8'h00;
    d1_rst = 1'b1; d1_start = 1'b0; d1_in_valid = 1'b0; d1_in_byte = 8'h00;
    d1_out_ready = 1'b1;
    tick(3);
    @(negedge clk);
    check_eq("rst_out_valid", int'(out_valid), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_in_ready", int'(in_ready), 0);
    check_eq("rst_out_coef", int'(out_coef), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    d1_rst = 1'b0;
    tick(1);

    // Bit ordering: LSB-first across byte boundaries.
    rdy_full = 1;
    got_q.delete();
    do_start();
    stim[0] = 8'h01; stim[1] = 8'h20; stim[2] = 8'h00;
    send_bytes(3, 0);
    wait_drain();
    check_eq("order_count", got_q.size(), 2);
    if (got_q.size() == 2) begin
      check_eq("order_c0", got_q[0], 1);
      check_eq("order_c1", got_q[1], 2);
    end
    do_reset();

    // Reduction boundaries: 4095 -> 766, 3329 -> 0, 3280 unchanged.
    got_q.delete();
    do_start();
    stim[0] = 8'hFF; stim[1] = 8'hFF; stim[2] = 8'hFF;
    stim[3] = 8'h01; stim[4] = 8'h0D; stim[5] = 8'hCD;
    send_bytes(6, 0);
    wait_drain();
    check_eq("mod_count", got_q.size(), 4);
    if (got_q.size() == 4) begin
      check_eq("mod_4095_a", got_q[0], 766);
      check_eq("mod_4095_b", got_q[1], 766);
      check_eq("mod_3329", got_q[2], 0);
      check_eq("mod_3280", got_q[3], 3280);
    end
    do_reset();

    // Full polynomial with random input gaps and random output stalls.
    dc = done_cnt;
    rdy_full = 0;
    rand_stim();
    do_start();
    send_bytes(NB, 30);
    wait_drain();
    tick(3);
    check_eq("full_hs_cnt", hs_cnt, NC);
    check_eq("full_done_cnt", done_cnt, dc + 1);
    check_eq("full_busy_after", int'(busy), 0);
    in_valid = 1'b1;
    in_byte  = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("post_in_ready", int'(in_ready), 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check_eq("post_bytes_acc", bytes_acc, NB);

    // Full polynomial with a 10-cycle backpressure window near the start.
    dc = done_cnt;
    rdy_full = 1;
    rand_stim();
    do_start();
    bp_req = 1;
    send_bytes(NB, 0);
    wait_drain();
    tick(3);
    check_eq("bp_hs_cnt", hs_cnt, NC);
    check_eq("bp_done_cnt", done_cnt, dc + 1);

    // Reset mid-stream, then a fresh decode with a stray start while busy.
    rdy_full = 0;
    rand_stim();
    do_start();
    send_bytes(100, 20);
    dc = done_cnt;
    rst = 1'b1;
    tick(1);
    @(negedge clk);
    check_eq("abort_out_valid", int'(out_valid), 0);
    check_eq("abort_busy", int'(busy), 0);
    check_eq("abort_in_ready", int'(in_ready), 0);
    check_eq("abort_done", int'(done), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick(3);
    check_eq("abort_no_done", done_cnt, dc);
    rand_stim();
    do_start();
    tick(2);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    @(negedge clk);
    check_eq("restart_busy", int'(busy), 1);
    @(posedge clk);
    #1;
    send_bytes(NB, 25);
    wait_drain();
    tick(3);
    check_eq("restart_hs_cnt", hs_cnt, NC);
    check_eq("restart_done_cnt", done_cnt, dc + 1);

    // D=1 instance: each bit of 0xA5 becomes one coefficient.
    d1_exp = '{1, 0, 1, 0, 0, 1, 0, 1};
    d1_start = 1'b1;
    tick(1);
    d1_start    = 1'b0;
    d1_in_byte  = 8'hA5;
    d1_in_valid = 1'b1;
    @(negedge clk);
    check_eq("d1_in_ready", int'(d1_in_ready), 1);
    @(posedge clk);
    #1;
    d1_in_valid = 1'b0;
    g = 0;
    while (d1_got.size() < 8 && g < 60) begin
      @(negedge clk);
      if (d1_out_valid && d1_out_ready) begin
        $display("d1 coef %0d: got %0d exp %0d", d1_got.size(), d1_out_coef,
                 d1_exp[d1_got.size()]);
        d1_got.push_back(int'(d1_out_coef));
      end
      g++;
    end
    check_eq("d1_count", d1_got.size(), 8);
    for (int i = 0; i < d1_got.size() && i < 8; i++)
      check_eq("d1_coef", d1_got[i], d1_exp[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
